fixed_predictor_decoder: RTL and testbench
==========================================

# fixed_predictor_decoder

Reconstructs PCM samples from the signed residual stream produced by the Rice residual decoder, using the FLAC fixed predictor of order 0–4. Sits directly downstream of the Rice stage and upstream of the sample output buffer. Consumes one residual per cycle and emits one sample per cycle. Warmup samples arrive verbatim on the same input ahead of the residuals.

## Interface
- DATA_WIDTH, 16, residual and sample width (signed two's complement)
- ACC_WIDTH, DATA_WIDTH+5, internal prediction accumulator width (covers coefficient magnitude sum 16)
- iClock  in  1  clock; all logic on rising edge
- iReset  in  1  asynchronous, active-high reset
- iStart  in  1  one-cycle pulse; latches iOrder and iBlockSize, clears history, begins a block
- iOrder  in  3  predictor order 0–4; values 5–7 are illegal
- iBlockSize  in  16  samples in block (warmup included); 0 is illegal
- iValid  in  1  iResidual carries a warmup sample or residual this cycle
- iResidual  in  DATA_WIDTH  signed warmup sample or residual
- oReady  out  1  high in WARMUP/DECODE; iValid is ignored while low
- oValid  out  1  oSample valid (one-cycle pulse per sample)
- oSample  out  DATA_WIDTH  reconstructed signed sample
- oDone  out  1  one-cycle pulse coincident with the last oValid of the block
- oError  out  1  sticky; set on illegal iOrder/iBlockSize at iStart, cleared by next legal iStart or reset

## Operation
- States: IDLE, WARMUP, DECODE, DONE.
- IDLE: oReady=0. iStart → WARMUP if order>0, else DECODE. An illegal order or size → DONE with oError=1, no oValid, no oDone.
- WARMUP: the first `order` accepted inputs are passed through unchanged as samples and pushed into history s1..s4 (s1 most recent). After the `order`-th → DECODE.
- DECODE: each accepted residual r produces the prediction:
  - order 0: r
  - order 1: r+s1
  - order 2: r+2s1−s2
  - order 3: r+3s1−3s2+s3
  - order 4: r+4s1−6s2+4s3−s4
- Arithmetic: sign-extend to ACC_WIDTH and sum. The output is the low DATA_WIDTH bits (modulo 2^DATA_WIDTH wrap, no saturation). The wrapped value is the value pushed into history.
- Sample counter increments per accepted input. The input that brings count to iBlockSize asserts oDone with its oValid, and the FSM goes to DONE.
- iBlockSize < order: the block ends inside WARMUP on the last sample, with oDone asserted.
- DONE: oReady=0. Returns to IDLE the next cycle.
- iStart in any state (including mid-block) aborts the current block: no oDone for the aborted block, history and counter are cleared, and the new order/size are latched. An iValid in the same cycle as iStart is ignored.
- History is unused beyond the order. Its contents between blocks are don't-care but must be cleared on iStart.

## Timing
- Reset values: state=IDLE, oReady=0, oValid=0, oDone=0, oError=0, oSample=0, history=0, counter=0.
- Latency: oSample/oValid are registered, one cycle after the accepting edge (iValid high while oReady high).
- Throughput: one sample per cycle, with no bubbles between warmup and decode.
- oReady rises the cycle after iStart. It falls the cycle after the edge that accepts the last input.
- Asynchronous reset mid-block drops all outputs to reset values immediately. No pending oValid survives.

## Test plan
- Order 0, size 3, inputs 5, −23, 7 → oValid ×3 with 5, −23, 7; oDone with the third.
- Order 2, size 5, inputs 10, 20, 0, 1, −1 → samples 10, 20, 30, 41, 51; oDone on 51.
- Order 4 wrap: warmup 32767, 32767, 32767, 32767, residual 1 → sample −32768 (wrapped); history then holds −32768.
- Order 3, size 2, inputs 4, 9 → samples 4, 9 only; oDone on 9; FSM ends in WARMUP→DONE→IDLE.
- iStart (order 1, size 4) after two samples of an order-2 block → no oDone for the first block; inputs 3, 2, −1, 0 → 3, 5, 4, 4 with oDone.
- iOrder=6 at iStart → oError=1, no oValid; the next legal iStart clears oError. Reset asserted mid-DECODE → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/fixed_predictor_decoder.sv
// FLAC fixed-predictor (order 0-4) sample reconstruction.
// Warmup samples pass through; residuals are added to a binomial prediction from history.
module fixed_predictor_decoder #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = DATA_WIDTH + 5
) (
   input  logic                         iClock,
   input  logic                         iReset,
   input  logic                         iStart,
   input  logic [2:0]                   iOrder,
   input  logic [15:0]                  iBlockSize,
   input  logic                         iValid,
   input  logic signed [DATA_WIDTH-1:0] iResidual,
   output logic                         oReady,
   output logic                         oValid,
   output logic signed [DATA_WIDTH-1:0] oSample,
   output logic                         oDone,
   output logic                         oError
);

   typedef enum logic [1:0] {IDLE, WARMUP, DECODE, DONE} state_t;

   state_t                       state;
   logic [2:0]                   order_q;
   logic [15:0]                  size_q;
   logic [15:0]                  count_q;
   logic [15:0]                  count_nx;
   logic signed [DATA_WIDTH-1:0] hist [1:4];

   logic signed [ACC_WIDTH-1:0]  r_x, s1_x, s2_x, s3_x, s4_x, acc;
   logic signed [DATA_WIDTH-1:0] pred, sample_d;
   logic                         accept, legal;
   logic                         acc_unused;

   localparam int EXT = ACC_WIDTH - DATA_WIDTH;

   assign r_x  = {{EXT{iResidual[DATA_WIDTH-1]}}, iResidual};
   assign s1_x = {{EXT{hist[1][DATA_WIDTH-1]}}, hist[1]};
   assign s2_x = {{EXT{hist[2][DATA_WIDTH-1]}}, hist[2]};
   assign s3_x = {{EXT{hist[3][DATA_WIDTH-1]}}, hist[3]};
   assign s4_x = {{EXT{hist[4][DATA_WIDTH-1]}}, hist[4]};

   // Binomial coefficients built from shifts and adds; the sum is taken modulo 2^ACC_WIDTH.
   always_comb begin
      acc = r_x;
      case (order_q)
         3'd1:    acc = r_x + s1_x;
         3'd2:    acc = r_x + (s1_x <<< 1) - s2_x;
         3'd3:    acc = r_x + (s1_x <<< 1) + s1_x - (s2_x <<< 1) - s2_x + s3_x;
         3'd4:    acc = r_x + (s1_x <<< 2) - (s2_x <<< 2) - (s2_x <<< 1) + (s3_x <<< 2) - s4_x;
         default: acc = r_x;
      endcase
   end

   // Output wraps to DATA_WIDTH; the upper accumulator bits are intentionally dropped.
   assign pred       = acc[DATA_WIDTH-1:0];
   assign acc_unused = ^acc[ACC_WIDTH-1:DATA_WIDTH];

   assign accept   = iValid && oReady && !iStart;
   assign sample_d = (state == WARMUP) ? iResidual : pred;
   assign count_nx = count_q + 16'd1;
   assign legal    = (iOrder <= 3'd4) && (iBlockSize != 16'd0);

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state   <= IDLE;
         order_q <= '0;
         size_q  <= '0;
         count_q <= '0;
         oReady  <= 1'b0;
         oValid  <= 1'b0;
         oSample <= '0;
         oDone   <= 1'b0;
         oError  <= 1'b0;
         for (int i = 1; i <= 4; i++) hist[i] <= '0;
      end else begin
         oValid <= 1'b0;
         oDone  <= 1'b0;
         if (iStart) begin
            // A start aborts whatever block is in flight, including its pending oDone.
            order_q <= iOrder;
            size_q  <= iBlockSize;
            count_q <= '0;
            for (int i = 1; i <= 4; i++) hist[i] <= '0;
            if (legal) begin
               state  <= (iOrder != 3'd0) ? WARMUP : DECODE;
               oReady <= 1'b1;
               oError <= 1'b0;
            end else begin
               state  <= DONE;
               oReady <= 1'b0;
               oError <= 1'b1;
            end
         end else begin
            case (state)
               WARMUP, DECODE: begin
                  if (accept) begin
                     oValid  <= 1'b1;
                     oSample <= sample_d;
                     hist[1] <= sample_d;
                     for (int i = 2; i <= 4; i++) hist[i] <= hist[i-1];
                     count_q <= count_nx;
                     if (count_nx == size_q) begin
                        oDone  <= 1'b1;
                        oReady <= 1'b0;
                        state  <= DONE;
                     end else if (state == WARMUP && count_nx == {13'd0, order_q}) begin
                        state <= DECODE;
                     end
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fixed_predictor_decoder.sv
// Scoreboard bench: a binomial-coefficient reference model queues expected samples; a monitor pops and compares.
module tb_fixed_predictor_decoder;

   logic               iClock = 1'b0;
   logic               iReset, iStart, iValid;
   logic [2:0]         iOrder;
   logic [15:0]        iBlockSize;
   logic signed [15:0] iResidual;
   logic               oReady, oValid, oDone, oError;
   logic signed [15:0] oSample;

   fixed_predictor_decoder #(.DATA_WIDTH(16)) dut (
      .iClock(iClock), .iReset(iReset), .iStart(iStart), .iOrder(iOrder),
      .iBlockSize(iBlockSize), .iValid(iValid), .iResidual(iResidual),
      .oReady(oReady), .oValid(oValid), .oSample(oSample), .oDone(oDone), .oError(oError)
   );

   always #5 iClock = ~iClock;

   typedef struct { int sample; bit done; } exp_t;
   exp_t q[$];
   int   n_cmp = 0, n_err = 0;

   // Reference model: prediction = sum of signed binomial coefficients times past samples.
   int coef [5][4] = '{'{0, 0, 0, 0}, '{1, 0, 0, 0}, '{2, -1, 0, 0}, '{3, -3, 1, 0}, '{4, -6, 4, -1}};
   int m_hist [4];
   int m_cnt, m_ord, m_size;
   bit m_act;

   task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_start(int ord, int size);
      m_ord  = ord;
      m_size = size;
      m_cnt  = 0;
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
      m_act  = (ord <= 4) && (size != 0);
   endtask

   task automatic model_step(int r, output int s, output bit d);
      longint acc;
      acc = r;
      if (m_cnt >= m_ord)
         for (int k = 0; k < 4; k++) acc += coef[m_ord][k] * m_hist[k];
      s = int'(shortint'(acc));
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = s;
      m_cnt++;
      d = (m_cnt == m_size);
      if (d) m_act = 0;
   endtask

   // Drive one cycle of input at the negedge; queue the expected sample if it will be accepted.
   task automatic cyc(bit v, int r);
      int s;
      bit d;
      exp_t e;
      d = 0;
      iValid    = v;
      iResidual = r[15:0];
      if (v && m_act) begin
         model_step(r, s, d);
         e.sample = s;
         e.done   = d;
         q.push_back(e);
      end
      @(negedge iClock);
      if (d) chk("ready_fall", oReady, 0);
   endtask

   task automatic start(int ord, int size);
      bit lg;
      iStart     = 1'b1;
      iOrder     = ord[2:0];
      iBlockSize = size[15:0];
      iValid     = 1'($urandom_range(0, 1));
      iResidual  = 16'($urandom);
      model_start(ord, size);
      lg = m_act;
      @(negedge iClock);
      iStart = 1'b0;
      iValid = 1'b0;
      chk("ready_after_start", oReady, lg);
      chk("error_after_start", oError, !lg);
   endtask

   function automatic int rnd_res();
      case ($urandom_range(0, 5))
         0:       return 32767;
         1:       return -32768;
         2:       return int'($urandom_range(0, 65535)) - 32768;
         default: return int'($urandom_range(0, 200)) - 100;
      endcase
   endfunction

   // Monitor: compare every presented sample against the queue head.
   always @(posedge iClock) begin
      exp_t e;
      #1;
      if (!iReset) begin
         if (oValid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_valid: got sample %0d expected no output at %0t", oSample, $time);
            end else begin
               e = q.pop_front();
               chk("sample", oSample, e.sample);
               chk("done", oDone, e.done);
            end
         end else if (oDone) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_done: got oDone=1 expected 0 (no oValid) at %0t", $time);
         end
      end
   end

   initial begin
      iReset = 1'b1; iStart = 1'b0; iValid = 1'b0;
      iOrder = '0; iBlockSize = '0; iResidual = '0;
      m_act = 0; m_ord = 0; m_size = 0; m_cnt = 0;
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
      repeat (2) @(negedge iClock);
      chk("rst_ready", oReady, 0);
      chk("rst_valid", oValid, 0);
      chk("rst_sample", oSample, 0);
      chk("rst_done", oDone, 0);
      chk("rst_error", oError, 0);
      iReset = 1'b0;
      @(negedge iClock);

      // Order 0 passthrough.
      start(0, 3);
      cyc(1, 5); cyc(1, -23); cyc(1, 7); cyc(0, 0);

      // Order 2: 10,20,30,41,51.
      start(2, 5);
      cyc(1, 10); cyc(1, 20); cyc(1, 0); cyc(1, 1); cyc(1, -1); cyc(0, 0);

      // Order 4 wrap, then one more residual that depends on the wrapped history.
      start(4, 6);
      for (int i = 0; i < 4; i++) cyc(1, 32767);
      cyc(1, 1); cyc(0, 0); cyc(1, 0); cyc(0, 0);

      // Block shorter than the order ends inside warmup.
      start(3, 2);
      cyc(1, 4); cyc(1, 9); cyc(1, 55); cyc(0, 0);

      // Abort an order-2 block after two samples.
      start(2, 5);
      cyc(1, 10); cyc(1, 20);
      start(1, 4);
      cyc(1, 3); cyc(1, 2); cyc(1, -1); cyc(1, 0); cyc(0, 0);

      // Illegal order, then illegal size, then a legal start clears the error.
      start(6, 4);
      cyc(1, 99); cyc(1, 98); cyc(0, 0);
      chk("error_sticky", oError, 1);
      start(1, 0);
      cyc(1, 12); cyc(0, 0);
      start(1, 2);
      cyc(1, 100); cyc(1, -3); cyc(0, 0);

      // Randomized blocks with bubbles, occasional aborts and illegal starts.
      for (int b = 0; b < 60; b++) begin
         int ord, size, guard;
         ord  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
         size = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 14));
         start(ord, size);
         guard = 0;
         while (m_act && guard < 200) begin
            if (m_cnt > 0 && $urandom_range(0, 40) == 0) break;
            cyc($urandom_range(0, 3) != 0, rnd_res());
            guard++;
         end
         if (m_act && guard >= 200) chk("block_timeout", guard, 0);
         if ($urandom_range(0, 1) == 1) cyc(0, 0);
      end

      // Asynchronous reset while a sample is being presented.
      start(2, 10);
      cyc(1, 7); cyc(1, 8); cyc(1, 9);
      iValid = 1'b0;
      @(posedge iClock);
      #2 iReset = 1'b1;
      #1;
      chk("arst_valid", oValid, 0);
      chk("arst_ready", oReady, 0);
      chk("arst_sample", oSample, 0);
      chk("arst_done", oDone, 0);
      chk("arst_error", oError, 0);
      q.delete();
      m_act = 0;
      @(negedge iClock);
      iReset = 1'b0;
      cyc(1, 5); cyc(0, 0); cyc(0, 0);

      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
